// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - sequences a 16:1 mux to serialise a registered word with a valid/ready output
module mux_scan_serializer #(
  parameter bit         MSB_FIRST = 1'b0,
  parameter logic [3:0] IDLE_SEL  = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  output logic [15:0] i,
  output logic [3:0]  s,
  input  logic        f,
  output logic        sout,
  output logic        sout_valid,
  input  logic        sout_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_HOLD} state_t;

  localparam logic [3:0] FIRST_SEL = MSB_FIRST ? 4'd15 : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] i_q, i_d;
  logic [3:0]  s_q, s_d;
  logic [3:0]  idx_q, idx_d;
  logic        sout_q, sout_d;
  logic        sout_valid_q, sout_valid_d;
  logic        done_q, done_d;

  logic       handshake;
  logic       last_bit;
  logic [3:0] next_sel;

  assign handshake = sout_valid_q && sout_ready;
  assign last_bit  = (idx_q == 4'd15);
  // The word ends on idx, so the select counter never relies on wrapping.
  assign next_sel  = MSB_FIRST ? (s_q - 4'd1) : (s_q + 4'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      i_q          <= 16'd0;
      s_q          <= IDLE_SEL;
      idx_q        <= 4'd0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      s_q          <= s_d;
      idx_q        <= idx_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD:   if (handshake) state_d = last_bit ? ST_IDLE : ST_SAMPLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    i_d          = i_q;
    s_d          = s_q;
    idx_d        = idx_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_d = IDLE_SEL;
        if (load) begin
          i_d   = din;
          idx_d = 4'd0;
          s_d   = FIRST_SEL;
        end
      end
      // s has been stable for a full cycle here, so f has settled.
      ST_SAMPLE: begin
        sout_d       = f;
        sout_valid_d = 1'b1;
      end
      ST_HOLD: begin
        if (handshake) begin
          sout_valid_d = 1'b0;
          if (last_bit) begin
            done_d = 1'b1;
            s_d    = IDLE_SEL;
          end else begin
            idx_d = idx_q + 4'd1;
            s_d   = next_sel;
          end
        end
      end
      default: ;
    endcase
  end

  assign i          = i_q;
  assign s          = s_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
